// File: rtl/bp_update_queue_pkg.sv
// Shared branch-predictor types and constants for the PHT update path.
// No latency or backpressure of its own; bhr_shift is shared with fetch.
package bp_update_queue_pkg;

    localparam int PC_SLICE_W  = 8;
    localparam int BHR_W       = 10;
    localparam int BP_UQ_DEPTH = 8;

    typedef struct packed {
        logic [PC_SLICE_W-1:0] pc_slice;
        logic [BHR_W-1:0]      bhr;
        logic                  pred_taken;
    } bp_meta_t;

    function automatic logic [BHR_W-1:0] bhr_shift(input logic [BHR_W-1:0] bhr,
                                                   input logic             taken);
        return {bhr[BHR_W-2:0], taken};
    endfunction

endpackage

// File: rtl/bp_update_queue_if.sv
// Fetch-enqueue, execute-resolve and PHT-update signals of the update queue.
// Pure wiring; backpressure is enq_ready_o only, resolve is never stalled.
interface bp_update_queue_if import bp_update_queue_pkg::*; #(
    parameter int DEPTH = BP_UQ_DEPTH
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  enq_valid_i;
    logic                  enq_ready_o;
    logic [PC_SLICE_W-1:0] enq_pc_slice_i;
    logic [BHR_W-1:0]      enq_bhr_i;
    logic                  enq_pred_taken_i;
    logic                  res_valid_i;
    logic                  res_taken_i;
    logic                  flush_i;
    logic                  update_en_o;
    logic [PC_SLICE_W-1:0] pc_slice_u_o;
    logic [BHR_W-1:0]      bhr_u_o;
    logic                  taken_u_o;
    logic                  mispredict_o;
    logic [BHR_W-1:0]      bhr_restore_o;
    logic [CNT_W-1:0]      count_o;
    logic                  res_err_o;

    modport master (
        output enq_valid_i, enq_pc_slice_i, enq_bhr_i, enq_pred_taken_i,
               res_valid_i, res_taken_i, flush_i,
        input  enq_ready_o, update_en_o, pc_slice_u_o, bhr_u_o, taken_u_o,
               mispredict_o, bhr_restore_o, count_o, res_err_o
    );

    modport slave (
        input  enq_valid_i, enq_pc_slice_i, enq_bhr_i, enq_pred_taken_i,
               res_valid_i, res_taken_i, flush_i,
        output enq_ready_o, update_en_o, pc_slice_u_o, bhr_u_o, taken_u_o,
               mispredict_o, bhr_restore_o, count_o, res_err_o
    );

endinterface

// File: rtl/bp_update_queue_meta_fifo.sv
// Synchronous FIFO of bp_meta_t with push/pop/clear; head is read combinationally.
// Zero-latency head; push ignored when full, pop ignored when empty, clear wins.
module bp_update_queue_meta_fifo import bp_update_queue_pkg::*; #(
    parameter  int DEPTH = BP_UQ_DEPTH,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  bp_meta_t         push_dat_i,
    output bp_meta_t         head_dat_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    bp_meta_t         mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign count_o    = count_q;
    assign head_dat_o = mem_q[rd_ptr_q];
    assign push_ok    = push_i & ~full_o & ~clear_i;
    assign pop_ok     = pop_i & ~empty_o & ~clear_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/bp_update_queue.sv
// In-order branch metadata queue driving the PHT update port and mispredict recovery.
// 1-cycle registered update/mispredict; enq stalls on full (no pop bypass), resolve never stalls.
module bp_update_queue import bp_update_queue_pkg::*; #(
    parameter  int DEPTH = BP_UQ_DEPTH,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    bp_update_queue_if.slave   bus
);

    bp_meta_t         head;
    bp_meta_t         enq_meta;
    logic             full, empty;
    logic [CNT_W-1:0] count;
    logic             res_fire, misp, push, pop, clear;

    logic                  update_en_q, update_en_d;
    logic [PC_SLICE_W-1:0] pc_u_q, pc_u_d;
    logic [BHR_W-1:0]      bhr_u_q, bhr_u_d;
    logic                  taken_u_q, taken_u_d;
    logic                  misp_q, misp_d;
    logic [BHR_W-1:0]      restore_q, restore_d;
    logic                  res_err_q, res_err_d;

    assign enq_meta = '{pc_slice:   bus.enq_pc_slice_i,
                        bhr:        bus.enq_bhr_i,
                        pred_taken: bus.enq_pred_taken_i};

    // A flush is an older event: it swallows the same-cycle resolve entirely.
    assign res_fire = bus.res_valid_i & ~empty & ~bus.flush_i;
    assign misp     = res_fire & (head.pred_taken != bus.res_taken_i);
    assign pop      = res_fire & ~misp;
    assign clear    = bus.flush_i | misp;
    assign push     = bus.enq_valid_i & ~full & ~clear;

    bp_update_queue_meta_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .push_i     (push),
        .pop_i      (pop),
        .clear_i    (clear),
        .push_dat_i (enq_meta),
        .head_dat_o (head),
        .full_o     (full),
        .empty_o    (empty),
        .count_o    (count)
    );

    always_comb begin
        update_en_d = res_fire;
        pc_u_d      = pc_u_q;
        bhr_u_d     = bhr_u_q;
        taken_u_d   = taken_u_q;
        misp_d      = misp;
        restore_d   = restore_q;
        res_err_d   = res_err_q | (bus.res_valid_i & empty);
        if (res_fire) begin
            pc_u_d    = head.pc_slice;
            bhr_u_d   = head.bhr;
            taken_u_d = bus.res_taken_i;
        end
        if (misp) restore_d = bhr_shift(head.bhr, bus.res_taken_i);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            update_en_q <= 1'b0;
            pc_u_q      <= '0;
            bhr_u_q     <= '0;
            taken_u_q   <= 1'b0;
            misp_q      <= 1'b0;
            restore_q   <= '0;
            res_err_q   <= 1'b0;
        end else begin
            update_en_q <= update_en_d;
            pc_u_q      <= pc_u_d;
            bhr_u_q     <= bhr_u_d;
            taken_u_q   <= taken_u_d;
            misp_q      <= misp_d;
            restore_q   <= restore_d;
            res_err_q   <= res_err_d;
        end
    end

    assign bus.enq_ready_o   = ~full;
    assign bus.update_en_o   = update_en_q;
    assign bus.pc_slice_u_o  = pc_u_q;
    assign bus.bhr_u_o       = bhr_u_q;
    assign bus.taken_u_o     = taken_u_q;
    assign bus.mispredict_o  = misp_q;
    assign bus.bhr_restore_o = restore_q;
    assign bus.count_o       = count;
    assign bus.res_err_o     = res_err_q;

endmodule

// File: tb/tb_bp_update_queue.sv
// Scoreboard bench for bp_update_queue: a queue model predicts every PHT update.
module tb_bp_update_queue;
    import bp_update_queue_pkg::*;

    typedef struct {
        logic [7:0] pc;
        logic [9:0] bhr;
        logic       taken;
        logic       misp;
        logic [9:0] restore;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    bp_meta_t   mq[$];
    exp_t       sb[$];
    logic       err_exp = 1'b0;
    logic [9:0] last_restore = '0;

    bp_update_queue_if bus ();

    bp_update_queue dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input logic ev, input logic [7:0] pc, input logic [9:0] bhr,
                        input logic pred, input logic rv, input logic rt, input logic fl);
        bp_meta_t h;
        logic     was_full;
        logic     m;
        was_full = (mq.size() == BP_UQ_DEPTH);
        m        = 1'b0;
        bus.enq_valid_i      = ev;
        bus.enq_pc_slice_i   = pc;
        bus.enq_bhr_i        = bhr;
        bus.enq_pred_taken_i = pred;
        bus.res_valid_i      = rv;
        bus.res_taken_i      = rt;
        bus.flush_i          = fl;
        if (rv && mq.size() == 0) err_exp = 1'b1;
        if (fl) begin
            mq.delete();
        end else begin
            if (rv && mq.size() != 0) begin
                h = mq[0];
                m = (h.pred_taken != rt);
                sb.push_back('{pc: h.pc_slice, bhr: h.bhr, taken: rt, misp: m,
                               restore: {h.bhr[8:0], rt}});
                if (m) mq.delete();
                else   void'(mq.pop_front());
            end
            if (ev && !was_full && !m)
                mq.push_back('{pc_slice: pc, bhr: bhr, pred_taken: pred});
        end
        tick();
        bus.enq_valid_i = 1'b0;
        bus.res_valid_i = 1'b0;
        bus.flush_i     = 1'b0;
    endtask

    task automatic enq(input logic [7:0] pc, input logic [9:0] bhr, input logic pred);
        step(1'b1, pc, bhr, pred, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic res(input logic rt);
        step(1'b0, 8'h0, 10'h0, 1'b0, 1'b1, rt, 1'b0);
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_cnt"}, 32'(bus.count_o), 32'(mq.size()));
        chk({tag, "_rdy"}, 32'(bus.enq_ready_o), 32'(mq.size() != BP_UQ_DEPTH));
        chk({tag, "_err"}, 32'(bus.res_err_o), 32'(err_exp));
    endtask

    task automatic do_reset(input logic rv);
        reset = 1'b1;
        bus.res_valid_i = rv;
        bus.res_taken_i = 1'b1;
        mq.delete();
        err_exp      = 1'b0;
        last_restore = '0;
        tick();
        tick();
        reset = 1'b0;
        bus.res_valid_i = 1'b0;
    endtask

    // Monitor: every update strobe must match the oldest scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.update_en_o === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("upd_unexp", 32'(bus.update_en_o), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("upd_pc",    32'(bus.pc_slice_u_o), 32'(e.pc));
                    chk("upd_bhr",   32'(bus.bhr_u_o),      32'(e.bhr));
                    chk("upd_taken", 32'(bus.taken_u_o),    32'(e.taken));
                    chk("upd_misp",  32'(bus.mispredict_o), 32'(e.misp));
                    if (e.misp) last_restore = e.restore;
                    chk("restore",   32'(bus.bhr_restore_o), 32'(last_restore));
                end
            end else begin
                chk("misp_idle", 32'(bus.mispredict_o), 32'd0);
            end
        end
    end

    initial begin
        bus.enq_valid_i      = 1'b0;
        bus.enq_pc_slice_i   = '0;
        bus.enq_bhr_i        = '0;
        bus.enq_pred_taken_i = 1'b0;
        bus.res_valid_i      = 1'b0;
        bus.res_taken_i      = 1'b0;
        bus.flush_i          = 1'b0;

        // 1: reset state
        do_reset(1'b0);
        check_state("rst");
        chk("rst_upd",     32'(bus.update_en_o),   32'd0);
        chk("rst_misp",    32'(bus.mispredict_o),  32'd0);
        chk("rst_restore", 32'(bus.bhr_restore_o), 32'd0);

        // 2: single correct prediction
        enq(8'h3A, 10'h155, 1'b1);
        check_state("t2_enq");
        res(1'b1);
        check_state("t2_res");

        // 3: mispredict at head squashes younger entries
        enq(8'h10, 10'h2AA, 1'b0);
        enq(8'h11, 10'h0F0, 1'b1);
        enq(8'h12, 10'h00F, 1'b0);
        check_state("t3_fill");
        res(1'b1);
        check_state("t3_misp");
        chk("t3_restore", 32'(bus.bhr_restore_o), 32'h155);
        tick();
        tick();

        // 4: advance pointers, fill to full across the wrap, then drain in order
        for (int i = 0; i < 3; i++) begin
            enq(8'(8'h50 + i), 10'(i * 7), 1'b0);
            res(1'b0);
        end
        for (int i = 0; i < BP_UQ_DEPTH; i++)
            enq(8'(8'h80 + i), 10'(10'h101 * i + 3), 1'(i & 1));
        check_state("t4_full");
        enq(8'hEE, 10'h3FF, 1'b1);
        check_state("t4_ninth");
        step(1'b1, 8'hEF, 10'h3FE, 1'b1, 1'b1, mq[0].pred_taken, 1'b0);
        check_state("t4_full_enqres");
        step(1'b1, 8'hF0, 10'h2F0, 1'b0, 1'b1, mq[0].pred_taken, 1'b0);
        check_state("t4_enqres");
        while (mq.size() != 0) res(mq[0].pred_taken);
        check_state("t4_drain");

        // 5: flush beats same-cycle resolve
        enq(8'h21, 10'h121, 1'b1);
        enq(8'h22, 10'h122, 1'b0);
        step(1'b0, 8'h0, 10'h0, 1'b0, 1'b1, 1'b0, 1'b1);
        check_state("t5_flush");
        tick();

        // 6: resolve on empty is sticky; reset with entries queued
        res(1'b1);
        check_state("t6_err");
        tick();
        tick();
        check_state("t6_sticky");
        for (int i = 0; i < 4; i++) enq(8'(8'hC0 + i), 10'(i), 1'b1);
        check_state("t6_four");
        do_reset(1'b1);
        check_state("t6_reset");
        tick();
        tick();
        chk("sb_drain", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
